// File: rtl/alu_vector_sequencer.sv
// -----------------------------------------------------------------------------
// alu_vector_sequencer
//
// Purpose:
//   Stimulus sequencer for the ALU datapath. A writable table of DEPTH vectors
//   (operand A, operand B, opcode) is loaded while idle. A start request then
//   issues entries 0..len-1 to the ALU over a valid/ready handshake, either
//   once or repeatedly (loop), and finishes with a one-cycle done pulse.
//
// Optional feature (macro SEQ_CHECK_EN):
//   Adds an expected-result column to the table and compares in-order ALU
//   results against it, reporting a sticky error flag and a saturating
//   error count. With the macro undefined none of that hardware exists.
//
// Ports:
//   clk      in   1      clock, rising edge
//   reset    in   1      asynchronous active-high reset
//   start    in   1      begin a sequence (sampled only in IDLE)
//   abort    in   1      synchronous return to IDLE, highest priority
//   loop     in   1      wrap to entry 0 after the last entry (sampled at wrap)
//   len      in   LW     vectors to issue, clamped to DEPTH, captured at start
//   wr_en    in   1      table write strobe (honoured only in IDLE)
//   wr_addr  in   IW     table write address
//   wr_a     in   WIDTH  table write data, operand A
//   wr_b     in   WIDTH  table write data, operand B
//   wr_op    in   OPW    table write data, opcode
//   wr_exp   in   WIDTH+1 table write data, expected result (SEQ_CHECK_EN)
//   res      in   WIDTH+1 ALU result (SEQ_CHECK_EN)
//   res_vld  in   1      ALU result strobe (SEQ_CHECK_EN)
//   err      out  1      sticky result-mismatch flag (SEQ_CHECK_EN)
//   err_cnt  out  8      saturating mismatch count (SEQ_CHECK_EN)
//   A        out  WIDTH  operand A to ALU (registered)
//   B        out  WIDTH  operand B to ALU (registered)
//   op       out  OPW    opcode to ALU (registered)
//   valid    out  1      A/B/op hold a live vector
//   ready    in   1      ALU accepts the vector when valid && ready
//   busy     out  1      sequencer not idle
//   done     out  1      one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module alu_vector_sequencer #(
    parameter  int WIDTH = 5,
    parameter  int OPW   = 1,
    parameter  int DEPTH = 4,
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             loop,
    input  logic [LW-1:0]    len,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_a,
    input  logic [WIDTH-1:0] wr_b,
    input  logic [OPW-1:0]   wr_op,
`ifdef SEQ_CHECK_EN
    input  logic [WIDTH:0]   wr_exp,
    input  logic [WIDTH:0]   res,
    input  logic             res_vld,
    output logic             err,
    output logic [7:0]       err_cnt,
`endif
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [OPW-1:0]   op,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic [LW-1:0]     r_len_q;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [OPW-1:0]    r_op;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    // Vector table
    logic [WIDTH-1:0]  r_tab_a  [DEPTH];
    logic [WIDTH-1:0]  r_tab_b  [DEPTH];
    logic [OPW-1:0]    r_tab_op [DEPTH];

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic              w_idle;
    logic              w_wr_ok;
    logic              w_xfer;
    logic              w_last;
    logic [LW-1:0]     w_len_clamped;
    logic [IW-1:0]     w_idx_nxt;
    logic              w_hit0;
    logic [WIDTH-1:0]  w_a0;
    logic [WIDTH-1:0]  w_b0;
    logic [OPW-1:0]    w_op0;

    assign w_idle        = (r_state == S_IDLE);
    // Abort outranks every other input, table writes included.
    assign w_wr_ok       = w_idle && wr_en && !abort && (32'(wr_addr) < DEPTH);
    assign w_xfer        = r_valid && ready;
    assign w_last        = (LW'(r_idx) == (r_len_q - LW'(1)));
    assign w_len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
    assign w_idx_nxt     = r_idx + IW'(1);

    // A write to entry 0 in the same cycle as start must be seen by the
    // vector presented on the following cycle, so forward it around the table.
    assign w_hit0 = w_wr_ok && (wr_addr == '0);
    assign w_a0   = w_hit0 ? wr_a  : r_tab_a[0];
    assign w_b0   = w_hit0 ? wr_b  : r_tab_b[0];
    assign w_op0  = w_hit0 ? wr_op : r_tab_op[0];

    // -------------------------------------------------------------------------
    // Vector table storage
    // -------------------------------------------------------------------------
    // NOTE: the table is cleared by reset because its contents are visible on
    // A/B/op after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tab_a[i]  <= '0;
                r_tab_b[i]  <= '0;
                r_tab_op[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_tab_a[wr_addr]  <= wr_a;
            r_tab_b[wr_addr]  <= wr_b;
            r_tab_op[wr_addr] <= wr_op;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_len_q <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (abort) begin
            // A transfer in this cycle still completes at the ALU; nothing
            // further is issued and done is not pulsed.
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_idx   <= '0;
                        r_len_q <= w_len_clamped;
                        r_busy  <= 1'b1;
                        if (len != '0) begin
                            r_state <= S_RUN;
                            r_a     <= w_a0;
                            r_b     <= w_b0;
                            r_op    <= w_op0;
                            r_valid <= 1'b1;
                        end else begin
                            // Empty sequence completes immediately.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (w_xfer) begin
                        if (!w_last) begin
                            r_idx <= w_idx_nxt;
                            r_a   <= r_tab_a[w_idx_nxt];
                            r_b   <= r_tab_b[w_idx_nxt];
                            r_op  <= r_tab_op[w_idx_nxt];
                        end else if (loop) begin
                            r_idx <= '0;
                            r_a   <= r_tab_a[0];
                            r_b   <= r_tab_b[0];
                            r_op  <= r_tab_op[0];
                        end else begin
                            r_state <= S_DONE;
                            r_idx   <= '0;
                            r_a     <= '0;
                            r_b     <= '0;
                            r_op    <= '0;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // start is deliberately not looked at here.
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    r_a     <= '0;
                    r_b     <= '0;
                    r_op    <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign A     = r_a;
    assign B     = r_b;
    assign op    = r_op;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

`ifdef SEQ_CHECK_EN
    // -------------------------------------------------------------------------
    // In-order result checker
    // -------------------------------------------------------------------------
    logic [WIDTH:0]    r_tab_exp [DEPTH];
    logic [IW-1:0]     r_chk_ptr;
    logic              r_err;
    logic [7:0]        r_err_cnt;
    logic              w_start_acc;
    logic              w_res_take;
    logic              w_chk_last;

    assign w_start_acc = w_idle && start && !abort;
    // Results are only meaningful while a sequence is live or just finishing;
    // an empty sequence has nothing to compare against.
    assign w_res_take  = res_vld && (r_state == S_RUN || r_state == S_DONE)
                         && (r_len_q != '0);
    assign w_chk_last  = (LW'(r_chk_ptr) == (r_len_q - LW'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tab_exp[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_tab_exp[wr_addr] <= wr_exp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chk_ptr <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_start_acc) begin
            r_chk_ptr <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_res_take) begin
            if (res != r_tab_exp[r_chk_ptr]) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
            // Pointer wraps with the issued sequence when looping.
            r_chk_ptr <= w_chk_last ? '0 : (r_chk_ptr + IW'(1));
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_vector_sequencer
//
// Directed-vector bench for alu_vector_sequencer (WIDTH=5, OPW=1, DEPTH=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// half a cycle away from the rising edge the DUT acts on. The checker section
// is only exercised when SEQ_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_vector_sequencer;

    localparam int WIDTH = 5;
    localparam int OPW   = 1;
    localparam int DEPTH = 4;
    localparam int IW    = 2;
    localparam int LW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic             loop;
    logic [LW-1:0]    len;
    logic             wr_en;
    logic [IW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_a;
    logic [WIDTH-1:0] wr_b;
    logic [OPW-1:0]   wr_op;
    logic [WIDTH:0]   wr_exp;
    logic [WIDTH:0]   res;
    logic             res_vld;
    logic             err;
    logic [7:0]       err_cnt;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [OPW-1:0]   op;
    logic             valid;
    logic             ready;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    // Bench copy of the table contents it has written.
    int m_a  [DEPTH];
    int m_b  [DEPTH];
    int m_op [DEPTH];

    alu_vector_sequencer #(
        .WIDTH (WIDTH),
        .OPW   (OPW),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .loop    (loop),
        .len     (len),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_a    (wr_a),
        .wr_b    (wr_b),
        .wr_op   (wr_op),
`ifdef SEQ_CHECK_EN
        .wr_exp  (wr_exp),
        .res     (res),
        .res_vld (res_vld),
        .err     (err),
        .err_cnt (err_cnt),
`endif
        .A       (A),
        .B       (B),
        .op      (op),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input int a, input int b, input int o);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_A"},     32'(A),     32'(a));
        check({tag, "_B"},     32'(B),     32'(b));
        check({tag, "_op"},    32'(op),    32'(o));
    endtask

    task automatic chk_entry(input string tag, input int idx);
        chk_vec(tag, m_a[idx], m_b[idx], m_op[idx]);
    endtask

    task automatic chk_quiet(input string tag, input logic exp_done, input logic exp_busy);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_done"},  32'(done),  32'(exp_done));
        check({tag, "_busy"},  32'(busy),  32'(exp_busy));
        check({tag, "_AB"},    32'({A, B, op}), 32'd0);
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic write_entry(input int addr, input int a, input int b, input int o, input int e);
        wr_en   = 1'b1;
        wr_addr = IW'(addr);
        wr_a    = WIDTH'(a);
        wr_b    = WIDTH'(b);
        wr_op   = OPW'(o);
        wr_exp  = (WIDTH + 1)'(e);
        m_a[addr]  = a;
        m_b[addr]  = b;
        m_op[addr] = o;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic kick(input int n, input logic lp, input logic rdy);
        start = 1'b1;
        len   = LW'(n);
        loop  = lp;
        ready = rdy;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat [5];
        int exp_idx;
        int n_xfer;
        int n_valid;
        int n_done;

        reset = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0; len = '0;
        wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0; wr_op = '0;
        wr_exp = '0; res = '0; res_vld = 1'b0; ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            m_a[i] = 0; m_b[i] = 0; m_op[i] = 0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk_quiet("rst", 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Cleared table reads back as zero
        kick(1, 1'b0, 1'b1);
        chk_vec("rst_tab", 0, 0, 0);
        @(negedge clk);
        check("rst_tab_done", 32'(done), 32'd1);
        @(negedge clk);

        // Test 1: single shot, len=3, ready held high
        write_entry(0, 11, 11, 0, 0);
        write_entry(1, 2, 3, 1, 0);
        write_entry(2, 12, 2, 1, 0);
        kick(3, 1'b0, 1'b1);
        chk_entry("t1_e0", 0);
        @(negedge clk);
        chk_entry("t1_e1", 1);
        @(negedge clk);
        chk_entry("t1_e2", 2);
        @(negedge clk);
        chk_quiet("t1_done", 1'b1, 1'b1);
        start = 1'b1;   // ignored while in DONE
        len   = 3'd3;
        @(negedge clk);
        start = 1'b0;
        chk_quiet("t1_after", 1'b0, 1'b0);
        @(negedge clk);
        chk_quiet("t1_ign_start", 1'b0, 1'b0);

        // Test 2: ready pattern 1,0,0,1,1
        pat = '{1, 0, 0, 1, 1};
        exp_idx = 0;
        n_xfer  = 0;
        kick(3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk_entry($sformatf("t2_c%0d", i), exp_idx);
            ready = pat[i][0];
            if (valid && ready) n_xfer++;
            if (pat[i] != 0) exp_idx++;
            @(negedge clk);
        end
        ready = 1'b1;
        check("t2_xfers", 32'(n_xfer), 32'd3);
        chk_quiet("t2_done", 1'b1, 1'b1);
        @(negedge clk);
        check("t2_done_once", 32'(done), 32'd0);

        // Test 3: len=2 looping, loop dropped at entry 1
        kick(2, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk_entry($sformatf("t3_c%0d", i), i % 2);
            if (i == 3) loop = 1'b0;
            @(negedge clk);
        end
        chk_quiet("t3_done", 1'b1, 1'b1);
        @(negedge clk);

        // Test 4a: len=0
        kick(0, 1'b0, 1'b1);
        chk_quiet("t4_len0", 1'b1, 1'b1);
        @(negedge clk);
        chk_quiet("t4_len0_end", 1'b0, 1'b0);

        // Test 4b: len=7 clamps to DEPTH
        write_entry(3, 7, 9, 1, 0);
        kick(7, 1'b0, 1'b1);
        n_valid = 0;
        n_done  = 0;
        for (int i = 0; i < 8; i++) begin
            if (valid) begin
                if (n_valid < DEPTH) chk_entry($sformatf("t4_v%0d", n_valid), n_valid);
                n_valid++;
            end
            if (done) n_done++;
            @(negedge clk);
        end
        check("t4_nvalid", 32'(n_valid), 32'd4);
        check("t4_ndone", 32'(n_done), 32'd1);

        // Test 5a: abort on 2nd vector
        kick(3, 1'b0, 1'b1);
        chk_entry("t5_e0", 0);
        @(negedge clk);
        chk_entry("t5_e1", 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_quiet("t5_abort", 1'b0, 1'b0);
        @(negedge clk);
        chk_quiet("t5_nodone", 1'b0, 1'b0);

        // Test 5b: write during RUN is dropped
        kick(3, 1'b0, 1'b0);
        chk_entry("t5_hold0", 0);
        wr_en = 1'b1; wr_addr = 2'd1; wr_a = 5'd31; wr_b = 5'd31; wr_op = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        chk_entry("t5_hold1", 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        kick(3, 1'b0, 1'b1);
        chk_entry("t5_rb0", 0);
        @(negedge clk);
        chk_entry("t5_rb1", 1);
        @(negedge clk);
        chk_entry("t5_rb2", 2);
        @(negedge clk);
        check("t5_rb_done", 32'(done), 32'd1);
        @(negedge clk);

        // Write in the same cycle as start is visible to that sequence
        wr_en = 1'b1; wr_addr = 2'd0; wr_a = 5'd3; wr_b = 5'd4; wr_op = 1'b0;
        m_a[0] = 3; m_b[0] = 4; m_op[0] = 0;
        kick(1, 1'b0, 1'b1);
        wr_en = 1'b0;
        chk_entry("t7_fwd", 0);
        @(negedge clk);
        check("t7_done", 32'(done), 32'd1);
        @(negedge clk);

        // Mid-sequence reset clears state and table
        kick(3, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_quiet("t8_rst", 1'b0, 1'b0);
        reset = 1'b0;
        kick(1, 1'b0, 1'b1);
        chk_vec("t8_tab", 0, 0, 0);
        @(negedge clk);
        @(negedge clk);

`ifdef SEQ_CHECK_EN
        // Test 6: result checker
        write_entry(0, 1, 2, 0, 22);
        write_entry(1, 3, 4, 1, 5);
        write_entry(2, 5, 6, 0, 14);
        kick(3, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            res_vld = 1'b1;
            res     = (i == 0) ? 6'd22 : (i == 1) ? 6'd6 : 6'd14;
            @(negedge clk);
        end
        res_vld = 1'b0;
        @(negedge clk);
        check("t6_err", 32'(err), 32'd1);
        check("t6_cnt", 32'(err_cnt), 32'd1);
        kick(0, 1'b0, 1'b1);
        check("t6_err_clr", 32'(err), 32'd0);
        check("t6_cnt_clr", 32'(err_cnt), 32'd0);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
